// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports with
// same-cycle bypass, and a clear engine that zeroes every entry after reset or on request.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic                busy_nxt, done_nxt;
    logic                drop0, drop1, wr0, wr1;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign drop0 = (ZERO_REG != 0) && (waddr0 == '0);
    assign drop1 = (ZERO_REG != 0) && (waddr1 == '0);
    assign wr1   = (state == IDLE) && we1 && !drop1;
    // Port 1 wins a same-address collision, so port 0 stands down.
    assign wr0   = (state == IDLE) && we0 && !drop0 && !(wr1 && (waddr1 == waddr0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SWEEP;
            cnt      <= '0;
            clr_busy <= 1'b1;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clr_busy <= busy_nxt;
            clr_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = clr_busy;
        done_nxt  = 1'b0;
        unique case (state)
            SWEEP: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (&cnt) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the array has no reset branch; the sweep defines its contents so it can map to plain RAM.
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0) mem[waddr0] <= wdata0;
            if (wr1) mem[waddr1] <= wdata1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (!rst && (state == IDLE) && !((ZERO_REG != 0) && (ra == '0)) && re[i]) begin
                if (wr1 && (waddr1 == ra))      rd = wdata1;
                else if (wr0 && (waddr0 == ra)) rd = wdata0;
                else                            rd = mem[ra];
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default config, a ZERO_REG=0 twin sharing its inputs,
// and a 4-read-port / 16-entry / 64-bit instance.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // default / ZERO_REG=0 pair
    logic        rst, we0, we1, clr_req;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata_a, rdata_b;
    logic        busy_a, done_a, busy_b, done_b;

    // wide instance
    logic         rst_w, we0_w, we1_w, clr_req_w;
    logic [3:0]   waddr0_w, waddr1_w;
    logic [63:0]  wdata0_w, wdata1_w;
    logic [3:0]   re_w;
    logic [15:0]  raddr_w;
    logic [255:0] rdata_w;
    logic         busy_w, done_w;

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata_a),
        .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
    );

    regfile_mp #(.ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata_b),
        .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) dut_w (
        .clk(clk), .rst(rst_w), .we0(we0_w), .we1(we1_w),
        .waddr0(waddr0_w), .waddr1(waddr1_w), .wdata0(wdata0_w), .wdata1(wdata1_w),
        .re(re_w), .raddr(raddr_w), .rdata(rdata_w),
        .clr_req(clr_req_w), .clr_busy(busy_w), .clr_done(done_w)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Counts edges until clr_done rises on the selected instance (0 = dut_a, 1 = dut_w).
    task automatic wait_done(input int which, input int exp_edges, input string tag);
        int  n = 0;
        logic d = 1'b0;
        while (!d && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            d = (which == 0) ? done_a : done_w;
        end
        check(tag, n, exp_edges);
    endtask

    localparam logic [63:0] V = 64'h0123_4567_89AB_CDEF;

    initial begin
        rst = 1'b1; we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; re = '0; raddr = '0;
        rst_w = 1'b1; we0_w = 1'b0; we1_w = 1'b0; clr_req_w = 1'b0;
        waddr0_w = '0; waddr1_w = '0; wdata0_w = '0; wdata1_w = '0; re_w = '0; raddr_w = '0;

        // reset state
        repeat (3) @(negedge clk);
        re = 2'b11; raddr = {5'd5, 5'd5};
        #1;
        check("rst_rdata", rdata_a, 64'h0);
        check("rst_busy", busy_a, 1'b1);
        check("rst_done", done_a, 1'b0);
        rst = 1'b0;

        wait_done(0, 32, "boot_sweep_len");
        check("boot_busy_low", busy_a, 1'b0);
        check("boot_done_b", done_b, 1'b1);
        @(posedge clk); #1;
        check("done_one_cycle", done_a, 1'b0);

        @(negedge clk); raddr = {5'd9, 5'd3};
        #1 check("post_sweep_read", rdata_a, 64'h0);

        // bypass and array read
        @(negedge clk); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF; raddr = {5'd5, 5'd5};
        #1 check("bypass_w0", rdata_a, {2{32'hDEAD_BEEF}});
        @(negedge clk); we0 = 1'b0;
        #1 check("array_r5", rdata_a, {2{32'hDEAD_BEEF}});

        // same-address collision
        @(negedge clk);
        we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7;
        wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222; raddr = {5'd7, 5'd7};
        #1 check("bypass_collide", rdata_a, {2{32'h2222_2222}});
        @(negedge clk); we0 = 1'b0; we1 = 1'b0;
        #1 check("array_collide", rdata_a, {2{32'h2222_2222}});

        // entry 0
        @(negedge clk); we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF; raddr = {5'd0, 5'd0};
        #1;
        check("r0_bypass_zr1", rdata_a, 64'h0);
        check("r0_bypass_zr0", rdata_b, {2{32'hFFFF_FFFF}});
        @(negedge clk); we0 = 1'b0;
        #1;
        check("r0_array_zr1", rdata_a, 64'h0);
        check("r0_array_zr0", rdata_b, {2{32'hFFFF_FFFF}});

        // read enable gating
        @(negedge clk); re = 2'b01; raddr = {5'd5, 5'd7};
        #1 check("re_gate", rdata_a, {32'h0, 32'h2222_2222});

        // fill r1..r31, then read back
        re = 2'b11;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk); we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i) * 32'h0101_0101;
        end
        @(negedge clk); we0 = 1'b0; raddr = {5'd31, 5'd1};
        #1 check("fill_readback", rdata_a, {32'h1F1F_1F1F, 32'h0101_0101});

        // requested sweep with writes attempted throughout
        clr_req = 1'b1;
        @(posedge clk); #1;
        check("req_busy", busy_a, 1'b1);
        clr_req = 1'b0;
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'hCAFE_F00D;
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1234_5678;
        raddr = {5'd2, 5'd9};
        #1 check("sweep_read", rdata_a, 64'h0);
        wait_done(0, 32, "req_sweep_len");
        we0 = 1'b0; we1 = 1'b0;
        #1 check("sweep_write_ignored", rdata_a, 64'h0);
        raddr = {5'd31, 5'd1};
        #1 check("sweep_cleared", rdata_a, 64'h0);

        // reset while the sweep is at entry 16
        @(negedge clk); clr_req = 1'b1;
        @(posedge clk); #1; clr_req = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        check("mid_rst_rdata", rdata_a, 64'h0);
        check("mid_rst_busy", busy_a, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done(0, 32, "mid_rst_restart_len");

        // wide instance: boot sweep
        @(negedge clk); rst_w = 1'b0;
        wait_done(1, 16, "w_boot_sweep_len");

        @(negedge clk);
        we1_w = 1'b1; waddr1_w = 4'd3; wdata1_w = V;
        re_w = 4'b1011; raddr_w = {4'd3, 4'd3, 4'd3, 4'd3};
        #1 check("w_bypass_re", rdata_w, {V, 64'h0, V, V});
        @(negedge clk);
        we1_w = 1'b0; re_w = 4'b1111; raddr_w = {4'd0, 4'd3, 4'd7, 4'd3};
        #1 check("w_array_read", rdata_w, {64'h0, V, 64'h0, V});

        // asynchronous reset from IDLE forces reads to zero at once
        #2 rst_w = 1'b1;
        #1;
        check("w_rst_async_rdata", rdata_w, 256'h0);
        check("w_rst_async_busy", busy_w, 1'b1);
        repeat (2) @(negedge clk);
        rst_w = 1'b0;
        wait_done(1, 16, "w_rst_sweep_len");

        // reset mid-sweep on the wide instance
        @(negedge clk); clr_req_w = 1'b1;
        @(posedge clk); #1; clr_req_w = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); rst_w = 1'b1;
        @(negedge clk); rst_w = 1'b0;
        wait_done(1, 16, "w_mid_rst_len");
        raddr_w = {4'd3, 4'd3, 4'd3, 4'd3};
        #1 check("w_cleared", rdata_w, 256'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
